// File: rtl/red_pitaya_exp_cond.sv
// -----------------------------------------------------------------------------
// red_pitaya_exp_cond
//
// Conditions the raw expansion-connector pins before they reach the
// housekeeping block. Each pin passes through a 2-flop synchronizer and a
// per-bit debouncer with a programmable length. The debounced levels feed
// sticky rise/fall capture, a masked event output and a saturating 32-bit
// rising-edge counter on one selectable pin. Control and status registers
// sit on the system bus slave interface.
//
// Ports
//   clk_i        clock
//   rstn_i       asynchronous active-low reset
//   exp_p_raw_i  raw P-side pins (asynchronous to clk_i)
//   exp_n_raw_i  raw N-side pins (asynchronous to clk_i)
//   exp_p_dat_o  conditioned P levels
//   exp_n_dat_o  conditioned N levels
//   evt_o        OR of (sticky edge bits & EVT_MASK), registered
//   sys_*        system bus slave (address decoded on [19:0])
//
// Register map (sys_addr[19:0])
//   0x00 CTRL      [0] DB_EN                          R/W
//   0x04 DB_LEN    [DBW-1:0]                          R/W
//   0x08 P_RISE    [DWE-1:0] sticky                   W1C
//   0x0C P_FALL    [DWE-1:0] sticky                   W1C
//   0x10 N_RISE    [DWE-1:0] sticky                   W1C
//   0x14 N_FALL    [DWE-1:0] sticky                   W1C
//   0x18 CNT_SEL   [3:0] P bits 0..DWE-1, N bits DWE..2*DWE-1
//   0x1C EVT_CNT   [31:0] read-only, any write clears
//   0x20 EVT_MASK  [2*DWE-1:0] over {N_RISE|N_FALL, P_RISE|P_FALL}
//   0x24 SYNC_RAW  {N_sync, P_sync}, read-only
// -----------------------------------------------------------------------------
module red_pitaya_exp_cond #(
  parameter int             DWE    = 8,
  parameter int             DBW    = 16,
  parameter logic [DBW-1:0] DB_RST = 16'd100
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [DWE-1:0] exp_p_raw_i,
  input  logic [DWE-1:0] exp_n_raw_i,
  output logic [DWE-1:0] exp_p_dat_o,
  output logic [DWE-1:0] exp_n_dat_o,
  output logic           evt_o,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  // Both sides are handled as one vector {N, P}: bit i < DWE is P[i],
  // bit i >= DWE is N[i-DWE]. This matches the CNT_SEL and EVT_MASK layout.
  localparam int NB = 2 * DWE;

  localparam logic [19:0] A_CTRL     = 20'h00000;
  localparam logic [19:0] A_DB_LEN   = 20'h00004;
  localparam logic [19:0] A_P_RISE   = 20'h00008;
  localparam logic [19:0] A_P_FALL   = 20'h0000C;
  localparam logic [19:0] A_N_RISE   = 20'h00010;
  localparam logic [19:0] A_N_FALL   = 20'h00014;
  localparam logic [19:0] A_CNT_SEL  = 20'h00018;
  localparam logic [19:0] A_EVT_CNT  = 20'h0001C;
  localparam logic [19:0] A_EVT_MASK = 20'h00020;
  localparam logic [19:0] A_SYNC_RAW = 20'h00024;

  localparam logic [DBW-1:0] DB_ZERO = {DBW{1'b0}};
  localparam logic [DBW-1:0] DB_ONE  = {{(DBW-1){1'b0}}, 1'b1};
  localparam logic [NB-1:0]  NB_ZERO = {NB{1'b0}};
  localparam logic [DWE-1:0] DW_ZERO = {DWE{1'b0}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NB-1:0]           sync1_r;
  logic [NB-1:0]           sync2_r;
  logic [NB-1:0][DBW-1:0]  db_cnt_r;
  logic [NB-1:0]           stable_r;
  logic [NB-1:0]           prev_r;
  logic [NB-1:0]           rise_sticky_r;
  logic [NB-1:0]           fall_sticky_r;
  logic                    db_en_r;
  logic [DBW-1:0]          db_len_r;
  logic [3:0]              cnt_sel_r;
  logic [31:0]             evt_cnt_r;
  logic [NB-1:0]           evt_mask_r;
  logic                    evt_r;
  logic                    ack_r;
  logic [31:0]             rdata_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [19:0]    addr_s;
  logic [NB-1:0]  raw_s;
  logic [DBW-1:0] db_lm1_s;
  logic [NB-1:0]  rise_s;
  logic [NB-1:0]  fall_s;
  logic [NB-1:0]  w1c_rise_s;
  logic [NB-1:0]  w1c_fall_s;
  logic           sel_rise_s;
  logic           cnt_clr_s;
  logic [31:0]    sel_ext_s;
  logic [31:0]    rd_mux_s;
  logic           unused_s;

  assign addr_s    = sys_addr[19:0];
  assign raw_s     = {exp_n_raw_i, exp_p_raw_i};
  assign sel_ext_s = {28'd0, cnt_sel_r};
  assign cnt_clr_s = sys_wen && (addr_s == A_EVT_CNT);
  assign unused_s  = ^{sys_addr[31:20], sys_wdata};

  // L-1 with L = max(DB_LEN, 1); a zero length behaves like a length of one.
  assign db_lm1_s = (db_len_r == DB_ZERO) ? DB_ZERO : (db_len_r - DB_ONE);

  assign rise_s = stable_r & ~prev_r;
  assign fall_s = ~stable_r & prev_r;

  // Write-1-to-clear masks for the sticky registers, assembled per side.
  always_comb begin
    w1c_rise_s = NB_ZERO;
    w1c_fall_s = NB_ZERO;
    if (sys_wen) begin
      w1c_rise_s = {(addr_s == A_N_RISE) ? sys_wdata[DWE-1:0] : DW_ZERO,
                    (addr_s == A_P_RISE) ? sys_wdata[DWE-1:0] : DW_ZERO};
      w1c_fall_s = {(addr_s == A_N_FALL) ? sys_wdata[DWE-1:0] : DW_ZERO,
                    (addr_s == A_P_FALL) ? sys_wdata[DWE-1:0] : DW_ZERO};
    end else begin
      w1c_rise_s = NB_ZERO;
      w1c_fall_s = NB_ZERO;
    end
  end

  // Rising edge of the pin chosen by CNT_SEL; out-of-range selects nothing.
  always_comb begin
    sel_rise_s = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (sel_ext_s == 32'(i)) begin
        sel_rise_s = rise_s[i];
      end else begin
        sel_rise_s = sel_rise_s;
      end
    end
  end

  // Read-data multiplexer.
  always_comb begin
    rd_mux_s = 32'd0;
    case (addr_s)
      A_CTRL:     rd_mux_s = {31'd0, db_en_r};
      A_DB_LEN:   rd_mux_s = {{(32-DBW){1'b0}}, db_len_r};
      A_P_RISE:   rd_mux_s = {{(32-DWE){1'b0}}, rise_sticky_r[DWE-1:0]};
      A_P_FALL:   rd_mux_s = {{(32-DWE){1'b0}}, fall_sticky_r[DWE-1:0]};
      A_N_RISE:   rd_mux_s = {{(32-DWE){1'b0}}, rise_sticky_r[NB-1:DWE]};
      A_N_FALL:   rd_mux_s = {{(32-DWE){1'b0}}, fall_sticky_r[NB-1:DWE]};
      A_CNT_SEL:  rd_mux_s = {28'd0, cnt_sel_r};
      A_EVT_CNT:  rd_mux_s = evt_cnt_r;
      A_EVT_MASK: rd_mux_s = {{(32-NB){1'b0}}, evt_mask_r};
      A_SYNC_RAW: rd_mux_s = {{(32-NB){1'b0}}, sync2_r};
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Two-flop synchronizer for every pin.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_r <= NB_ZERO;
      sync2_r <= NB_ZERO;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debouncer: the output follows the synced level only after it has
  // differed for L consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stable_r <= NB_ZERO;
      db_cnt_r <= {NB{DB_ZERO}};
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!db_en_r) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] >= db_lm1_s) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= DB_ZERO;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Edge history and sticky capture; a new edge beats a coincident clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prev_r        <= NB_ZERO;
      rise_sticky_r <= NB_ZERO;
      fall_sticky_r <= NB_ZERO;
    end else begin
      prev_r        <= stable_r;
      rise_sticky_r <= (rise_sticky_r & ~w1c_rise_s) | rise_s;
      fall_sticky_r <= (fall_sticky_r & ~w1c_fall_s) | fall_s;
    end
  end

  // Masked event output, registered from the sticky bits.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      evt_r <= 1'b0;
    end else begin
      evt_r <= |((rise_sticky_r | fall_sticky_r) & evt_mask_r);
    end
  end

  // Read/write control registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      db_en_r    <= 1'b1;
      db_len_r   <= DB_RST;
      cnt_sel_r  <= 4'd0;
      evt_mask_r <= NB_ZERO;
    end else if (sys_wen) begin
      case (addr_s)
        A_CTRL:     db_en_r    <= sys_wdata[0];
        A_DB_LEN:   db_len_r   <= sys_wdata[DBW-1:0];
        A_CNT_SEL:  cnt_sel_r  <= sys_wdata[3:0];
        A_EVT_MASK: evt_mask_r <= sys_wdata[NB-1:0];
        default:    db_en_r    <= db_en_r;
      endcase
    end else begin
      db_en_r <= db_en_r;
    end
  end

  // Saturating rising-edge counter; a clear coincident with a rise yields 1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      evt_cnt_r <= 32'd0;
    end else if (cnt_clr_s) begin
      evt_cnt_r <= sel_rise_s ? 32'd1 : 32'd0;
    end else if (sel_rise_s && (evt_cnt_r != 32'hFFFF_FFFF)) begin
      evt_cnt_r <= evt_cnt_r + 32'd1;
    end else begin
      evt_cnt_r <= evt_cnt_r;
    end
  end

  // Bus response: acknowledge one cycle after any strobe, data with it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ack_r   <= sys_wen | sys_ren;
      rdata_r <= sys_ren ? rd_mux_s : 32'd0;
    end
  end

  assign exp_p_dat_o = stable_r[DWE-1:0];
  assign exp_n_dat_o = stable_r[NB-1:DWE];
  assign evt_o       = evt_r;
  assign sys_ack     = ack_r;
  assign sys_rdata   = rdata_r;
  assign sys_err     = 1'b0;

endmodule
